// File: rtl/sum_latch_pkg.sv
// sum_latch_pkg: shared UART states, framing constants and byte-count helper
// Macro SUM_LATCH_PARITY_EN adds an even-parity bit (8E1, 11 bits per frame).
package sum_latch_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_START_BIT,
      S_DATA_BITS,
`ifdef SUM_LATCH_PARITY_EN
      S_PARITY_BIT,
`endif
      S_STOP_BIT
   } uart_state_t;
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
`ifdef SUM_LATCH_PARITY_EN
   localparam int FRAME_BITS = 1 + DATA_BITS + 1 + STOP_BITS;
`else
   localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
`endif
   function automatic int nbytes(input int width);
      return (width + 8) / 8;
   endfunction
endpackage

// File: rtl/sum_latch_uart_tx_byte.sv
// uart_tx_byte: serialises one byte as an 8N1 (or 8E1) UART frame
// Ports: clk, rst_n (async active-low), data/load (byte and request, taken in
// IDLE or in the last stop-bit cycle for back-to-back frames), tx (registered
// serial line, idle high), frame_done (high during the last stop-bit cycle).
// Macro SUM_LATCH_PARITY_EN inserts the parity bit.
module uart_tx_byte
   import sum_latch_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       load,
   output logic       tx,
   output logic       frame_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   uart_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] sh_q, sh_d;
   logic tx_q, tx_d;
   logic bit_end;
`ifdef SUM_LATCH_PARITY_EN
   logic par_q, par_d;
`endif
   always_comb begin
      bit_end = cnt_q == CW'(CLKS_PER_BIT - 1);
      frame_done = state_q == S_STOP_BIT && bit_end;
      state_d = state_q;
      cnt_d = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + CW'(1);
      bit_d = bit_q;
      sh_d = sh_q;
`ifdef SUM_LATCH_PARITY_EN
      par_d = par_q;
`endif
      case (state_q)
         S_IDLE:      if (load) state_d = S_START_BIT;
         S_START_BIT: if (bit_end) state_d = S_DATA_BITS;
         S_DATA_BITS: if (bit_end) begin
            sh_d = sh_q >> 1;
            bit_d = bit_q + 3'd1;
`ifdef SUM_LATCH_PARITY_EN
            if (bit_q == 3'd7) state_d = S_PARITY_BIT;
`else
            if (bit_q == 3'd7) state_d = S_STOP_BIT;
`endif
         end
`ifdef SUM_LATCH_PARITY_EN
         S_PARITY_BIT: if (bit_end) state_d = S_STOP_BIT;
`endif
         S_STOP_BIT:  if (bit_end) state_d = load ? S_START_BIT : S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (load && (state_q == S_IDLE || frame_done)) begin
         sh_d = data;
`ifdef SUM_LATCH_PARITY_EN
         par_d = ^data;
`endif
      end
      // tx is registered from the next state so the line changes on the same edge as the state
      tx_d = state_d == S_START_BIT ? 1'b0 :
             state_d == S_DATA_BITS ? sh_d[0] :
`ifdef SUM_LATCH_PARITY_EN
             state_d == S_PARITY_BIT ? par_d :
`endif
             1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         sh_q <= '0;
         tx_q <= 1'b1;
`ifdef SUM_LATCH_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         tx_q <= tx_d;
`ifdef SUM_LATCH_PARITY_EN
         par_q <= par_d;
`endif
      end
   end
   assign tx = tx_q;
endmodule

// File: rtl/sum_latch_uart_tx.sv
// sum_latch_uart_tx: latched WIDTH-bit adder whose sum is sent LSB-byte-first over UART
// Ports: clk, rst_n (async active-low), a/b operands, start request,
// sum/carry latched result, tx serial line, busy, done (one-cycle pulse).
// Macro SUM_LATCH_PARITY_EN selects 8E1 framing instead of 8N1.
module sum_latch_uart_tx
   import sum_latch_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   output logic [WIDTH:0]   sum,
   output logic             carry,
   output logic             tx,
   output logic             busy,
   output logic             done
);
   localparam int NBYTES = nbytes(WIDTH);
   localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
   logic [WIDTH:0] sum_q, sum_d;
   logic [IW-1:0] idx_q, idx_d;
   logic busy_q, busy_d, done_q, done_d;
   logic accept, last, load, frame_done;
   logic [NBYTES*8-1:0] ext_d;
   logic [7:0] byte_d;
   always_comb begin
      accept = start && !busy_q;
      last = idx_q == IW'(NBYTES - 1);
      load = accept || (frame_done && !last);
      sum_d = accept ? {1'b0, a} + {1'b0, b} : sum_q;
      idx_d = accept ? '0 : (frame_done && !last) ? idx_q + IW'(1) : idx_q;
      busy_d = accept ? 1'b1 : (frame_done && last) ? 1'b0 : busy_q;
      done_d = frame_done && last;
      // the byte loaded this edge comes from the next sum/index, covering both a fresh start and a follow-on frame
      ext_d = (NBYTES*8)'(sum_d);
      byte_d = ext_d[8*idx_d +: 8];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         idx_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         idx_q <= idx_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk        (clk),
      .rst_n      (rst_n),
      .data       (byte_d),
      .load       (load),
      .tx         (tx),
      .frame_done (frame_done)
   );
   assign sum = sum_q;
   assign carry = sum_q[WIDTH];
   assign busy = busy_q;
   assign done = done_q;
endmodule
